// File: rtl/axi_decerr_slave_pkg.sv
// axi_pkg: AXI response/burst constants and FSM state types shared by the default slave.
package axi_pkg;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
endpackage

// File: rtl/axi_decerr_slave_if.sv
// axi_decerr_slave_if: AXI read/write channel bundle with master and slave views.
interface axi_decerr_slave_if #(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
);
  logic [ID_W-1:0]     arid, rid, awid, bid;
  logic [ADDR_W-1:0]   araddr, awaddr;
  logic [LEN_W-1:0]    arlen, awlen;
  logic [2:0]          arsize, awsize;
  logic [1:0]          arburst, awburst, rresp, bresp;
  logic                arvalid, arready, rlast, rvalid, rready;
  logic                awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [DATA_W-1:0]   rdata, wdata;
  logic [DATA_W/8-1:0] wstrb;
  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    output arready, rid, rdata, rresp, rlast, rvalid,
    output awready, wready, bid, bresp, bvalid
  );
  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    input  arready, rid, rdata, rresp, rlast, rvalid,
    input  awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/axi_decerr_slave_sat_counter.sv
// sat_counter: synchronous-reset up-counter that holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (inc && !(&cnt_q)) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/axi_decerr_slave.sv
// axi_decerr_slave: default AXI slave answering every burst with an error response.
module axi_decerr_slave
  import axi_pkg::*;
#(
  parameter int              ID_W       = 8,
  parameter int              ADDR_W     = 32,
  parameter int              DATA_W     = 32,
  parameter int              LEN_W      = 4,
  parameter logic [1:0]      RESP_CODE  = AXI_RESP_DECERR,
  parameter logic [DATA_W-1:0] RDATA_FILL = '0,
  parameter int              CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  axi_decerr_slave_if.slave bus,
  output logic [CNT_W-1:0] rd_err_cnt,
  output logic [CNT_W-1:0] wr_err_cnt,
  output logic             wlast_mismatch
);
  rd_state_e        rs_q, rs_d;
  wr_state_e        ws_q, ws_d;
  logic [ID_W-1:0]  rid_q, rid_d, bid_q, bid_d;
  logic [LEN_W-1:0] rcnt_q, rcnt_d, wcnt_q, wcnt_d;
  logic             mm_q, mm_d;
  logic             ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic             unused;
  assign unused = ^{bus.araddr, bus.arsize, bus.arburst, bus.awaddr, bus.awsize,
                    bus.awburst, bus.wdata, bus.wstrb};
  // handshakes are qualified by the rst-gated ready/valid outputs below
  assign ar_hs = bus.arvalid & bus.arready;
  assign r_hs  = bus.rvalid & bus.rready;
  assign aw_hs = bus.awvalid & bus.awready;
  assign w_hs  = bus.wvalid & bus.wready;
  assign b_hs  = bus.bvalid & bus.bready;
  assign bus.arready = !rst && rs_q == R_IDLE;
  assign bus.rvalid  = !rst && rs_q == R_DATA;
  assign bus.rid     = rid_q;
  assign bus.rdata   = RDATA_FILL;
  assign bus.rresp   = RESP_CODE;
  assign bus.rlast   = rcnt_q == '0;
  assign bus.awready = !rst && ws_q == W_IDLE;
  assign bus.wready  = !rst && ws_q == W_DATA;
  assign bus.bvalid  = !rst && ws_q == W_RESP;
  assign bus.bid     = bid_q;
  assign bus.bresp   = RESP_CODE;
  assign wlast_mismatch = mm_q;
  always_comb begin
    rs_d   = rs_q;
    rid_d  = rid_q;
    rcnt_d = rcnt_q;
    if (ar_hs) begin
      rs_d   = R_DATA;
      rid_d  = bus.arid;
      rcnt_d = bus.arlen;
    end else if (r_hs) begin
      rs_d   = rcnt_q == '0 ? R_IDLE : R_DATA;
      rcnt_d = rcnt_q == '0 ? rcnt_q : rcnt_q - LEN_W'(1);
    end
  end
  always_comb begin
    ws_d   = ws_q;
    bid_d  = bid_q;
    wcnt_d = wcnt_q;
    mm_d   = mm_q;
    if (aw_hs) begin
      ws_d   = W_DATA;
      bid_d  = bus.awid;
      wcnt_d = bus.awlen;
    end else if (w_hs) begin
      ws_d   = bus.wlast ? W_RESP : W_DATA;
      wcnt_d = wcnt_q == '0 ? wcnt_q : wcnt_q - LEN_W'(1);
      // early WLAST, or a beat past AWLEN+1 without WLAST
      mm_d   = mm_q | (bus.wlast ^ (wcnt_q == '0));
    end else if (b_hs) begin
      ws_d   = W_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rs_q   <= R_IDLE;
      ws_q   <= W_IDLE;
      rid_q  <= '0;
      bid_q  <= '0;
      rcnt_q <= '0;
      wcnt_q <= '0;
      mm_q   <= 1'b0;
    end else begin
      rs_q   <= rs_d;
      ws_q   <= ws_d;
      rid_q  <= rid_d;
      bid_q  <= bid_d;
      rcnt_q <= rcnt_d;
      wcnt_q <= wcnt_d;
      mm_q   <= mm_d;
    end
  end
  sat_counter #(.W(CNT_W)) u_rd_cnt (.clk(clk), .rst(rst), .inc(r_hs && bus.rlast), .cnt(rd_err_cnt));
  sat_counter #(.W(CNT_W)) u_wr_cnt (.clk(clk), .rst(rst), .inc(b_hs), .cnt(wr_err_cnt));
endmodule

// File: tb/tb_axi_decerr_slave.sv
// tb_axi_decerr_slave: scoreboard bench for the AXI default error slave.
module tb_axi_decerr_slave;
  typedef struct packed {
    logic [7:0] id;
    logic       last;
  } rbeat_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] rd_err_cnt, wr_err_cnt;
  logic        wlast_mismatch;
  int          checks = 0;
  int          failures = 0;
  rbeat_t      rq[$];
  logic [7:0]  bq[$];
  rbeat_t      re;
  logic [7:0]  be;
  axi_decerr_slave_if bus ();
  axi_decerr_slave dut (
    .clk(clk), .rst(rst), .bus(bus),
    .rd_err_cnt(rd_err_cnt), .wr_err_cnt(wr_err_cnt), .wlast_mismatch(wlast_mismatch)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end
  // accepted beats are compared against the expectations queued at address time
  always @(negedge clk) begin
    if (!rst && bus.rvalid && bus.rready) begin
      checks++;
      if (rq.size() == 0) begin
        failures++;
        $display("FAIL r_extra: unexpected beat rid=%h rlast=%b", bus.rid, bus.rlast);
      end else begin
        re = rq.pop_front();
        if ({bus.rid, bus.rlast, bus.rresp, bus.rdata} !== {re.id, re.last, 2'b11, 32'h0}) begin
          failures++;
          $display("FAIL r_beat: got rid=%h rlast=%b rresp=%b rdata=%h, want rid=%h rlast=%b rresp=11 rdata=0",
                   bus.rid, bus.rlast, bus.rresp, bus.rdata, re.id, re.last);
        end
      end
    end
    if (!rst && bus.bvalid && bus.bready) begin
      checks++;
      if (bq.size() == 0) begin
        failures++;
        $display("FAIL b_extra: unexpected response bid=%h", bus.bid);
      end else begin
        be = bq.pop_front();
        if ({bus.bid, bus.bresp} !== {be, 2'b11}) begin
          failures++;
          $display("FAIL b_resp: got bid=%h bresp=%b, want bid=%h bresp=11", bus.bid, bus.bresp, be);
        end
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    @(negedge clk);
    checks++;
    if ({bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid} !== 5'b0) begin
      failures++;
      $display("FAIL reset_hs: got ar/aw/w/r/b=%b, want 00000",
               {bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid});
    end
    tick;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.arready, bus.awready, bus.rvalid, bus.bvalid, bus.rid, bus.bid, rd_err_cnt, wr_err_cnt, wlast_mismatch}
        !== {4'b1100, 8'h0, 8'h0, 16'h0, 16'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got arr=%b awr=%b rv=%b bv=%b rid=%h bid=%h rc=%0d wc=%0d mm=%b",
               bus.arready, bus.awready, bus.rvalid, bus.bvalid, bus.rid, bus.bid, rd_err_cnt, wr_err_cnt, wlast_mismatch);
    end
    tick;
  endtask
  task automatic test_single_read;
    bus.arvalid = 1'b1;
    bus.arid    = 8'h5A;
    bus.arlen   = 4'd0;
    bus.rready  = 1'b1;
    rq.push_back('{id: 8'h5A, last: 1'b1});
    @(negedge clk);
    checks++;
    if (bus.arready !== 1'b1) begin
      failures++;
      $display("FAIL single_arready: got %b want 1", bus.arready);
    end
    tick;
    bus.arvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.rvalid !== 1'b1) begin
      failures++;
      $display("FAIL single_latency: rvalid=%b want 1 one cycle after AR", bus.rvalid);
    end
    tick;
    @(negedge clk);
    checks++;
    if (bus.rvalid !== 1'b0 || rd_err_cnt !== 16'd1) begin
      failures++;
      $display("FAIL single_done: got rvalid=%b rd_err_cnt=%0d want 0,1", bus.rvalid, rd_err_cnt);
    end
    tick;
  endtask
  task automatic test_burst_stall;
    int   beats = 0;
    int   cyc = 0;
    logic pend = 1'b0;
    logic plast = 1'b0;
    bus.arvalid = 1'b1;
    bus.arid    = 8'hC3;
    bus.arlen   = 4'd3;
    bus.rready  = 1'b0;
    for (int i = 0; i < 4; i++) rq.push_back('{id: 8'hC3, last: i == 3});
    tick;
    bus.arvalid = 1'b0;
    while (beats < 4 && cyc < 40) begin
      bus.rready = (cyc % 2 == 0);
      @(negedge clk);
      checks++;
      if (bus.rvalid !== 1'b1 || bus.rid !== 8'hC3 || bus.arready !== 1'b0) begin
        failures++;
        $display("FAIL burst_hold: got rvalid=%b rid=%h arready=%b want 1,c3,0", bus.rvalid, bus.rid, bus.arready);
      end
      if (pend) begin
        checks++;
        if (bus.rlast !== plast) begin
          failures++;
          $display("FAIL burst_stable: rlast=%b changed during stall, want %b", bus.rlast, plast);
        end
      end
      pend  = !bus.rready;
      plast = bus.rlast;
      if (bus.rready) beats++;
      tick;
      cyc++;
    end
    if (beats < 4) begin
      checks++;
      failures++;
      $display("FAIL burst_timeout: got %0d beats want 4", beats);
    end
    bus.rready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.arready !== 1'b1 || bus.rvalid !== 1'b0 || rd_err_cnt !== 16'd2) begin
      failures++;
      $display("FAIL burst_done: got arready=%b rvalid=%b rd_err_cnt=%0d want 1,0,2", bus.arready, bus.rvalid, rd_err_cnt);
    end
    tick;
  endtask
  task automatic test_write_ok;
    bus.wvalid = 1'b1;
    bus.wlast  = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.wready !== 1'b0) begin
      failures++;
      $display("FAIL w_before_aw: wready=%b want 0", bus.wready);
    end
    tick;
    bus.wvalid  = 1'b0;
    bus.awvalid = 1'b1;
    bus.awid    = 8'h21;
    bus.awlen   = 4'd2;
    bus.bready  = 1'b0;
    bq.push_back(8'h21);
    tick;
    bus.awvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.wvalid = 1'b1;
      bus.wlast  = (i == 2);
      @(negedge clk);
      checks++;
      if (bus.wready !== 1'b1 || bus.bvalid !== 1'b0) begin
        failures++;
        $display("FAIL w_beat%0d: got wready=%b bvalid=%b want 1,0", i, bus.wready, bus.bvalid);
      end
      tick;
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.bvalid !== 1'b1 || bus.bid !== 8'h21 || bus.bresp !== 2'b11) begin
        failures++;
        $display("FAIL b_hold%0d: got bvalid=%b bid=%h bresp=%b want 1,21,11", i, bus.bvalid, bus.bid, bus.bresp);
      end
      tick;
    end
    bus.bready = 1'b1;
    tick;
    bus.bready = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_err_cnt !== 16'd1 || wlast_mismatch !== 1'b0 || bus.bvalid !== 1'b0) begin
      failures++;
      $display("FAIL write_done: got wr_err_cnt=%0d mm=%b bvalid=%b want 1,0,0", wr_err_cnt, wlast_mismatch, bus.bvalid);
    end
    tick;
  endtask
  task automatic test_wlast_early;
    bus.awvalid = 1'b1;
    bus.awid    = 8'h44;
    bus.awlen   = 4'd3;
    bq.push_back(8'h44);
    tick;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b1;
    bus.wlast   = 1'b0;
    tick;
    bus.wlast   = 1'b1;
    tick;
    bus.wvalid  = 1'b0;
    bus.wlast   = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.bvalid !== 1'b1 || bus.wready !== 1'b0 || wlast_mismatch !== 1'b1) begin
      failures++;
      $display("FAIL early_wlast: got bvalid=%b wready=%b mm=%b want 1,0,1", bus.bvalid, bus.wready, wlast_mismatch);
    end
    tick;
    bus.bready = 1'b1;
    tick;
    bus.bready = 1'b0;
    tick;
    @(negedge clk);
    checks++;
    if (wr_err_cnt !== 16'd2 || wlast_mismatch !== 1'b1) begin
      failures++;
      $display("FAIL early_sticky: got wr_err_cnt=%0d mm=%b want 2,1", wr_err_cnt, wlast_mismatch);
    end
    tick;
  endtask
  task automatic test_concurrent;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (wlast_mismatch !== 1'b0 || rd_err_cnt !== 16'd0 || wr_err_cnt !== 16'd0) begin
      failures++;
      $display("FAIL rst_clear: got mm=%b rc=%0d wc=%0d want 0,0,0", wlast_mismatch, rd_err_cnt, wr_err_cnt);
    end
    tick;
    bus.arvalid = 1'b1;
    bus.arid    = 8'h11;
    bus.arlen   = 4'd1;
    bus.awvalid = 1'b1;
    bus.awid    = 8'h22;
    bus.awlen   = 4'd0;
    rq.push_back('{id: 8'h11, last: 1'b0});
    rq.push_back('{id: 8'h11, last: 1'b1});
    bq.push_back(8'h22);
    @(negedge clk);
    checks++;
    if (bus.arready !== 1'b1 || bus.awready !== 1'b1) begin
      failures++;
      $display("FAIL both_ready: got arready=%b awready=%b want 1,1", bus.arready, bus.awready);
    end
    tick;
    bus.arvalid = 1'b0;
    bus.awvalid = 1'b0;
    bus.rready  = 1'b1;
    bus.bready  = 1'b1;
    bus.wvalid  = 1'b1;
    bus.wlast   = 1'b1;
    tick;
    bus.wvalid  = 1'b0;
    bus.wlast   = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.rvalid !== 1'b1 || bus.bvalid !== 1'b1) begin
      failures++;
      $display("FAIL concurrent_valid: got rvalid=%b bvalid=%b want 1,1", bus.rvalid, bus.bvalid);
    end
    tick;
    bus.bready = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_err_cnt !== 16'd1 || wr_err_cnt !== 16'd1) begin
      failures++;
      $display("FAIL concurrent_cnt: got rc=%0d wc=%0d want 1,1", rd_err_cnt, wr_err_cnt);
    end
    tick;
  endtask
  task automatic test_reset_mid_burst;
    bus.arvalid = 1'b1;
    bus.arid    = 8'h77;
    bus.arlen   = 4'd7;
    bus.rready  = 1'b1;
    rq.push_back('{id: 8'h77, last: 1'b0});
    rq.push_back('{id: 8'h77, last: 1'b0});
    tick;
    bus.arvalid = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    bus.rready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.rvalid !== 1'b0) begin
      failures++;
      $display("FAIL rst_rvalid: got %b want 0 during reset", bus.rvalid);
    end
    tick;
    rst = 1'b0;
    bus.rready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.arready !== 1'b1 || bus.rvalid !== 1'b0 || rd_err_cnt !== 16'd0) begin
      failures++;
      $display("FAIL rst_abort: got arready=%b rvalid=%b rc=%0d want 1,0,0", bus.arready, bus.rvalid, rd_err_cnt);
    end
    repeat (4) tick;
    @(negedge clk);
    checks++;
    if (bus.rvalid !== 1'b0 || rq.size() != 0 || bq.size() != 0) begin
      failures++;
      $display("FAIL drain: got rvalid=%b pending r=%0d b=%0d want 0,0,0", bus.rvalid, rq.size(), bq.size());
    end
    tick;
  endtask
  initial begin
    {bus.arvalid, bus.awvalid, bus.wvalid, bus.wlast, bus.rready, bus.bready} = '0;
    {bus.arid, bus.awid, bus.arlen, bus.awlen} = '0;
    {bus.araddr, bus.awaddr, bus.arsize, bus.awsize, bus.arburst, bus.awburst} = '0;
    bus.wdata = 32'hDEAD_BEEF;
    bus.wstrb = 4'hF;
    test_reset;
    test_single_read;
    test_burst_stall;
    test_write_ok;
    test_wlast_early;
    test_concurrent;
    test_reset_mid_burst;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_decerr_slave.md
Name: axi_decerr_slave

Overview:
- Parametrised AXI default slave for the interconnect; terminates every transaction whose address decodes to no real slave.
- Full burst support: read bursts return ARLEN+1 beats with RLAST only on the final beat.
- Read and write paths are independent FSMs, so a read and a write can be in flight at the same time.
- Saturating error counters and a WLAST-mismatch sticky flag are provided for debug/CSR visibility.

Parameters:
ID_W, 8, width of ARID/AWID/RID/BID
ADDR_W, 32, address width (addresses are accepted and ignored)
DATA_W, 32, data width; STRB width = DATA_W/8
LEN_W, 4, burst length field width
RESP_CODE, 2'b11, value driven on RRESP/BRESP (DECERR)
RDATA_FILL, 0, constant driven on RDATA
CNT_W, 16, width of error counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID_W/ADDR_W/LEN_W/3/2  read address
ARVALID in 1; ARREADY out 1  read address handshake
RID/RDATA/RRESP/RLAST/RVALID  out  ID_W/DATA_W/2/1/1  read data
RREADY  in  1  read data ready
AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID_W/ADDR_W/LEN_W/3/2  write address
AWVALID in 1; AWREADY out 1  write address handshake
WDATA/WSTRB/WLAST/WVALID  in  DATA_W/DATA_W/8/1/1  write data (discarded)
WREADY  out  1  write data ready
BID/BRESP/BVALID  out  ID_W/2/1  write response
BREADY  in  1  write response ready
rd_err_cnt  out  CNT_W  count of completed read bursts
wr_err_cnt  out  CNT_W  count of completed write bursts
wlast_mismatch  out  1  sticky: WLAST not aligned with AWLEN+1

Behaviour:
- Reset: synchronous, active-high. While rst=1 the FSMs go to IDLE; RID=BID=0, beat counters=0, err counters=0, wlast_mismatch=0; ARREADY, AWREADY, WREADY, RVALID and BVALID are all 0.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1 (not gated on ARVALID).
  - On ARVALID&ARREADY: RID<=ARID, rcnt<=ARLEN, go to R_DATA. First RVALID appears the next cycle.
  - R_DATA: RVALID=1, RDATA=RDATA_FILL, RRESP=RESP_CODE, RLAST=(rcnt==0) combinationally.
  - On RVALID&RREADY: if rcnt==0, go to R_IDLE and increment rd_err_cnt; else rcnt<=rcnt-1.
  - ARREADY=0 in R_DATA, so there is one read outstanding at a time. At most one read beat is issued per cycle.
  - RVALID stays high with stable data while RREADY=0.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: AWREADY=1.
  - On AWVALID&AWREADY: BID<=AWID, wcnt<=AWLEN, go to W_DATA.
  - W_DATA: WREADY=1. On each W handshake, wcnt decrements (no wrap below 0).
    - On a handshake with WLAST=1: go to W_RESP. If wcnt!=0 at that beat, set wlast_mismatch.
    - On a handshake with wcnt==0 and WLAST=0: set wlast_mismatch and stay in W_DATA until WLAST arrives.
  - W_RESP: BVALID=1, BRESP=RESP_CODE. On BREADY: go to W_IDLE and increment wr_err_cnt.
- Simultaneous events:
  - AR and AW handshakes in the same cycle are both accepted; the two FSMs are independent.
  - R and B completions in the same cycle increment both counters.
- Counters saturate at all-ones and do not wrap.
- wlast_mismatch clears only on reset.
- A W beat presented before the AW handshake is not accepted (WREADY=0 outside W_DATA).
- Reset asserted mid-burst aborts the transaction immediately; no further beats or responses are issued after reset releases.
- ARSIZE, ARBURST, AWSIZE, AWBURST, addresses and WSTRB are ignored.

Decomposition:
- Shared package axi_pkg holds the AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR constants, the burst-type constants and the FSM state enums rd_state_e and wr_state_e.
- One natural sub-module: sat_counter (parameter W; inputs clk, rst, inc; output cnt). Instantiate it twice.
- Read and write FSMs stay inline in the top module.

Test Plan:
- Reset, then ARID=8'h5A, ARLEN=0, RREADY=1 → one beat: RVALID the cycle after the AR handshake, RID=5A, RRESP=2'b11, RDATA=0, RLAST=1; rd_err_cnt=1.
- ARLEN=3 with RREADY toggling 1,0,1,0... → exactly 4 beats; RLAST only on the 4th; RVALID and RID held stable during stalls; ARREADY=0 until the last beat is accepted.
- AWID=8'h21, AWLEN=2, three W beats with WLAST on the 3rd, BREADY held low for 5 cycles → BVALID held for 5 cycles with BID=21, BRESP=2'b11; wr_err_cnt=1 after BREADY; wlast_mismatch=0.
- AWLEN=3 with WLAST on the 2nd beat → W_RESP entered after beat 2; wlast_mismatch=1 and stays 1 until rst.
- AR (ARLEN=1) and AW (AWLEN=0) handshaken in the same cycle → the read burst and write response complete concurrently; both counters reach 1.
- rst pulsed high for 1 cycle during beat 2 of an ARLEN=7 burst → RVALID=0 during reset; ARREADY=1 the cycle after rst deasserts; rd_err_cnt=0.
